// File: rtl/simple_cpu_pkg.sv
// Shared constants for simple_8bit_cpu: opcodes, instruction field positions and the fixed program ROM.
// Optional SIMPLE_CPU_ALU_ZFLAG_EN (used in the top) makes ALU writes also update zero_flag.
package simple_cpu_pkg;

  localparam int DATA_W = 8;
  localparam int PC_W   = 4;

  localparam logic [2:0] OP_MOV = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;  // shared with CMP, split by src[2]
  localparam logic [2:0] OP_JMP = 3'b111;  // shared with JZ, split by dest[1]

  localparam int OP_MSB   = 7;
  localparam int OP_LSB   = 5;
  localparam int DEST_MSB = 4;
  localparam int DEST_LSB = 3;
  localparam int SRC_MSB  = 2;
  localparam int SRC_LSB  = 0;

  function automatic logic [DATA_W-1:0] rom_word(input logic [PC_W-1:0] addr);
    logic [DATA_W-1:0] word;
    case (addr)
      4'd0:    word = 8'h02;  // MOV R0,#2
      4'd1:    word = 8'h0B;  // MOV R1,#3
      4'd2:    word = 8'h10;  // MOV R2,#0
      4'd3:    word = 8'h19;  // MOV R3,#1
      4'd4:    word = 8'h30;  // ADD R2,R0
      4'd5:    word = 8'h51;  // MUL R2,R1
      4'd6:    word = 8'h61;  // AND R0,R1
      4'd7:    word = 8'h81;  // OR  R0,R1
      4'd8:    word = 8'hA8;  // XOR R1,R0
      4'd9:    word = 8'hD8;  // NOT R3
      4'd10:   word = 8'hCF;  // CMP R1,R3
      4'd11:   word = 8'hF3;  // JZ  3
      4'd12:   word = 8'h03;  // MOV R0,#3
      default: word = 8'hED;  // JMP 13 (halt loop)
    endcase
    return word;
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Four-entry register file: two combinational read ports, one synchronous write port,
// synchronous active-low clear that overrides any pending write.
module cpu_regfile
  import simple_cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic [1:0]        write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [1:0]        rd_addr,
  input  logic [1:0]        rs_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] rs_data
);

  logic [DATA_W-1:0] registers [0:3];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_reg
      always_ff @(posedge clk) begin
        if (!reset)
          registers[gi] <= '0;
        else if (write_en && (write_addr == 2'(gi)))
          registers[gi] <= write_data;
      end
    end
  endgenerate

  assign rd_data = registers[rd_addr];
  assign rs_data = registers[rs_addr];

endmodule

// File: rtl/simple_8bit_cpu.sv
// Single-cycle 8-bit CPU running a fixed 16-word program; CPI = 1.
// Define SIMPLE_CPU_ALU_ZFLAG_EN to have every register write also update zero_flag.
module simple_8bit_cpu
  import simple_cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] pc
);

  logic [DATA_W-1:0] instruction;
  logic [2:0]        opcode;
  logic [1:0]        dest;
  logic [2:0]        src;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rs_val;
  logic [2*DATA_W-1:0] product;
  logic              write_en;
  logic [DATA_W-1:0] write_data;
  logic              zero_flag;
  logic              zero_flag_next;
  logic [PC_W-1:0]   pc_next;
  logic [PC_W-1:0]   jump_target;

  assign instruction = rom_word(pc);
  assign opcode      = instruction[OP_MSB:OP_LSB];
  assign dest        = instruction[DEST_MSB:DEST_LSB];
  assign src         = instruction[SRC_MSB:SRC_LSB];
  assign jump_target = {dest[0], src};
  assign product     = rd_val * rs_val;

  cpu_regfile REGFILE (
    .clk        (clk),
    .reset      (reset),
    .write_en   (write_en),
    .write_addr (dest),
    .write_data (write_data),
    .rd_addr    (dest),
    .rs_addr    (src[1:0]),
    .rd_data    (rd_val),
    .rs_data    (rs_val)
  );

  always_comb begin
    write_en       = 1'b1;
    write_data     = '0;
    pc_next        = pc + 1'b1;
    zero_flag_next = zero_flag;
    case (opcode)
      OP_MOV: write_data = {5'b0, src};
      OP_ADD: write_data = rd_val + rs_val;
      OP_MUL: write_data = product[DATA_W-1:0];
      OP_AND: write_data = rd_val & rs_val;
      OP_OR:  write_data = rd_val | rs_val;
      OP_XOR: write_data = rd_val ^ rs_val;
      OP_NOT: begin
        if (src[2]) begin
          write_en       = 1'b0;
          zero_flag_next = (rd_val == rs_val);
        end else begin
          write_data = ~rd_val;
        end
      end
      default: begin
        write_en = 1'b0;
        // JZ reads the flag as it stands before this edge
        if (!dest[1] || zero_flag)
          pc_next = jump_target;
      end
    endcase
`ifdef SIMPLE_CPU_ALU_ZFLAG_EN
    if (write_en)
      zero_flag_next = (write_data == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc        <= '0;
      zero_flag <= 1'b0;
    end else begin
      pc        <= pc_next;
      zero_flag <= zero_flag_next;
    end
  end

endmodule

// File: tb/tb_simple_8bit_cpu.sv
// Scoreboard bench for simple_8bit_cpu: driver queues the expected architectural state after
// each clock edge, a monitor pops and compares it against pc and the internal state.
module tb_simple_8bit_cpu;

  logic       clk;
  logic       reset;
  logic [3:0] pc;

  simple_8bit_cpu dut (
    .clk   (clk),
    .reset (reset),
    .pc    (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] pc;
    logic [7:0] r0;
    logic [7:0] r1;
    logic [7:0] r2;
    logic [7:0] r3;
    logic       zf;
  } exp_t;

  // Hand-traced state after k edges from reset release
  exp_t tbl [0:13] = '{
    '{4'd0,  8'h00, 8'h00, 8'h00, 8'h00, 1'b0},
    '{4'd1,  8'h02, 8'h00, 8'h00, 8'h00, 1'b0},
    '{4'd2,  8'h02, 8'h03, 8'h00, 8'h00, 1'b0},
    '{4'd3,  8'h02, 8'h03, 8'h00, 8'h00, 1'b0},
    '{4'd4,  8'h02, 8'h03, 8'h00, 8'h01, 1'b0},
    '{4'd5,  8'h02, 8'h03, 8'h02, 8'h01, 1'b0},
    '{4'd6,  8'h02, 8'h03, 8'h06, 8'h01, 1'b0},
    '{4'd7,  8'h02, 8'h03, 8'h06, 8'h01, 1'b0},
    '{4'd8,  8'h03, 8'h03, 8'h06, 8'h01, 1'b0},
    '{4'd9,  8'h03, 8'h00, 8'h06, 8'h01, 1'b0},
    '{4'd10, 8'h03, 8'h00, 8'h06, 8'hFE, 1'b0},
    '{4'd11, 8'h03, 8'h00, 8'h06, 8'hFE, 1'b0},
    '{4'd12, 8'h03, 8'h00, 8'h06, 8'hFE, 1'b0},
    '{4'd13, 8'h03, 8'h00, 8'h06, 8'hFE, 1'b0}
  };

  exp_t exp_q [$];
  int   total = 0;
  int   bad   = 0;
  int   txn   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic step_push(input int k);
    @(posedge clk);
    #1;
    exp_q.push_back(tbl[k]);
  endtask

  // Monitor: one line per checked cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc", {4'b0, pc}, {4'b0, e.pc});
        check("r0", dut.REGFILE.registers[0], e.r0);
        check("r1", dut.REGFILE.registers[1], e.r1);
        check("r2", dut.REGFILE.registers[2], e.r2);
        check("r3", dut.REGFILE.registers[3], e.r3);
        check("zero_flag", {7'b0, dut.zero_flag}, {7'b0, e.zf});
        $display("txn %0d: pc=%0d r0=%02h r1=%02h r2=%02h r3=%02h zf=%0b", txn, pc,
                 dut.REGFILE.registers[0], dut.REGFILE.registers[1],
                 dut.REGFILE.registers[2], dut.REGFILE.registers[3], dut.zero_flag);
        txn++;
      end
    end
  end

  initial begin
    int wait_cycles;
    reset = 1'b0;
    step_push(0);
    step_push(0);
    reset = 1'b1;
    for (int k = 1; k <= 13; k++) step_push(k);
    for (int k = 0; k < 12; k++) step_push(13);

    // Restart, run to pc=7 then reset for one edge so the OR never commits
    reset = 1'b0;
    step_push(0);
    reset = 1'b1;
    for (int k = 1; k <= 7; k++) step_push(k);
    reset = 1'b0;
    step_push(0);
    reset = 1'b1;
    for (int k = 1; k <= 13; k++) step_push(k);
    for (int k = 0; k < 3; k++) step_push(13);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
